// File: rtl/timer_cnt_cmp_pkg.sv
// Shared constants for the timer counter / compare block: bus address map,
// bus and counter widths.
package timer_cnt_cmp_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned DIV_W  = 4;

  // Register map; TCMP0/TCMP1 live in the upstream compare register block.
  localparam logic [ADDR_W-1:0] TDR0_ADDR  = 13'h04;
  localparam logic [ADDR_W-1:0] TDR1_ADDR  = 13'h08;
  localparam logic [ADDR_W-1:0] TCMP0_ADDR = 13'h0C;
  localparam logic [ADDR_W-1:0] TCMP1_ADDR = 13'h10;
  localparam logic [ADDR_W-1:0] TISR_ADDR  = 13'h18;

endpackage

// File: rtl/timer_cnt_cmp_if.sv
// Register bus between the bus master and the timer counter block.
//   addr, wr_data, wr_en : master -> timer
//   rd_data              : timer -> master (combinational read mux)
interface timer_cnt_cmp_if;
  import timer_cnt_cmp_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  modport master (output addr, output wr_data, output wr_en, input rd_data);
  modport slave  (input addr, input wr_data, input wr_en, output rd_data);

endinterface

// File: rtl/timer_cnt_cmp_prescaler.sv
// Clock prescaler for the timer counter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   timer_en   : counter run enable; when low div_cnt is cleared, no tick
//   halt       : freeze div_cnt and suppress tick (debug halt)
//   div_en     : 0 = tick every cycle, 1 = tick every (div_val+1) cycles
//   div_val    : divide value
//   tick_c     : combinational count-enable pulse for the counter
module timer_cnt_cmp_prescaler
  import timer_cnt_cmp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             halt,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick_c
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             div_hit;

  assign div_hit = (div_cnt_q == div_val);

  // Next divider count and tick
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick_c    = 1'b0;
    if (!timer_en) begin
      div_cnt_d = '0;
    end else if (!halt) begin
      if (!div_en) begin
        div_cnt_d = '0;
        tick_c    = 1'b1;
      end else if (div_hit) begin
        div_cnt_d = '0;
        tick_c    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/timer_cnt_cmp.sv
// 64-bit timer counter with prescaler, compare match and sticky W1C interrupt
// status. Decodes TDR0/TDR1/TISR on the register bus.
// Optional feature macro: TIMER_HALT_EN (halt_req freezes counting/compare).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : addr, wr_data, wr_en in; rd_data out (combinational)
//   timer_en      : counter run enable
//   div_en/div_val: prescaler control
//   int_en        : compare interrupt enable
//   halt_req      : debug halt request (only used with TIMER_HALT_EN)
//   tcmp0/tcmp1   : compare value low/high word
//   tim_int       : interrupt output (registered status bit)
module timer_cnt_cmp
  import timer_cnt_cmp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  timer_cnt_cmp_if.slave    bus,
  input  logic              timer_en,
  input  logic              div_en,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              int_en,
  input  logic              halt_req,
  input  logic [DATA_W-1:0] tcmp0,
  input  logic [DATA_W-1:0] tcmp1,
  output logic              tim_int
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             int_st_q, int_st_d;
  logic             tick;
  logic             halt;
  logic             int_set, int_clr;

`ifdef TIMER_HALT_EN
  assign halt = halt_req;
`else
  logic unused_halt_req;
  assign halt            = 1'b0;
  assign unused_halt_req = halt_req;
`endif

  timer_cnt_cmp_prescaler u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .timer_en (timer_en),
    .halt     (halt),
    .div_en   (div_en),
    .div_val  (div_val),
    .tick_c   (tick)
  );

  // Counter: advance on tick while running, software load only while stopped
  always_comb begin
    cnt_d = cnt_q;
    if (timer_en) begin
      if (tick) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.wr_en) begin
      if (bus.addr == TDR0_ADDR)      cnt_d[31:0]  = bus.wr_data;
      else if (bus.addr == TDR1_ADDR) cnt_d[63:32] = bus.wr_data;
    end
  end

  // Compare match (held while halted) and sticky status; set beats clear
  always_comb begin
    match_d  = halt ? match_q : (timer_en & (cnt_q == {tcmp1, tcmp0}));
    int_set  = match_q & int_en & ~halt;
    int_clr  = bus.wr_en & (bus.addr == TISR_ADDR) & bus.wr_data[0];
    int_st_d = int_set | (int_st_q & ~int_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      match_q  <= 1'b0;
      int_st_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      int_st_q <= int_st_d;
    end
  end

  assign tim_int = int_st_q;

  // Zero-latency read mux
  always_comb begin
    bus.rd_data = '0;
    unique case (bus.addr)
      TDR0_ADDR: bus.rd_data = cnt_q[31:0];
      TDR1_ADDR: bus.rd_data = cnt_q[63:32];
      TISR_ADDR: bus.rd_data = {31'b0, int_st_q};
      default:   bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_cnt_cmp.sv
// Scoreboard bench for timer_cnt_cmp: stimulus pushes expected values,
// a negedge monitor pops and compares while chk_stb is high.
module tb_timer_cnt_cmp;
  import timer_cnt_cmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timer_en, div_en, int_en, halt_req;
  logic [3:0]  div_val;
  logic [31:0] tcmp0, tcmp1;
  logic        tim_int;
  logic        chk_stb;

  timer_cnt_cmp_if bus_if ();

  timer_cnt_cmp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .int_en   (int_en),
    .halt_req (halt_req),
    .tcmp0    (tcmp0),
    .tcmp1    (tcmp1),
    .tim_int  (tim_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_int;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: compare one expected item per strobed cycle
  always @(negedge clk) begin
    if (chk_stb) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_underflow: monitor strobed with empty scoreboard");
      end else begin
        exp_t        e;
        logic [31:0] act;
        e   = sb_q.pop_front();
        act = e.is_int ? {31'b0, tim_int} : bus_if.rd_data;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d);
    bus_if.addr    = a;
    bus_if.wr_data = d;
    bus_if.wr_en   = 1'b1;
    step();
    bus_if.wr_en   = 1'b0;
  endtask

  task automatic do_read(input string nm, input logic [12:0] a, input logic [31:0] e);
    exp_t it;
    it.name = nm; it.is_int = 1'b0; it.exp = e;
    bus_if.addr = a;
    sb_q.push_back(it);
    chk_stb = 1'b1;
    step();
    chk_stb = 1'b0;
  endtask

  task automatic chk_int(input string nm, input logic e);
    exp_t it;
    it.name = nm; it.is_int = 1'b1; it.exp = {31'b0, e};
    sb_q.push_back(it);
    chk_stb = 1'b1;
    step();
    chk_stb = 1'b0;
  endtask

  task automatic load_cnt(input logic [63:0] v);
    do_write(TDR0_ADDR, v[31:0]);
    do_write(TDR1_ADDR, v[63:32]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0;
    int_en = 1'b0; halt_req = 1'b0; tcmp0 = 32'hFFFF_FFFF; tcmp1 = 32'hFFFF_FFFF;
    chk_stb = 1'b0;
    bus_if.addr = '0; bus_if.wr_data = '0; bus_if.wr_en = 1'b0;
    step(2);
    do_read("rst_tdr0", TDR0_ADDR, 32'h0);
    rst_n = 1'b1;
    step();
    do_read("rst_tdr1", TDR1_ADDR, 32'h0);
    do_read("rst_tisr", TISR_ADDR, 32'h0);
    chk_int("rst_int", 1'b0);
    do_read("unmapped", 13'h0C, 32'h0);

    // Software load, then wrap
    load_cnt(64'hFFFF_FFFF_FFFF_FFFE);
    do_read("load_lo", TDR0_ADDR, 32'hFFFF_FFFE);
    do_read("load_hi", TDR1_ADDR, 32'hFFFF_FFFF);
    timer_en = 1'b1;
    step();
    timer_en = 1'b0;
    do_read("max_lo", TDR0_ADDR, 32'hFFFF_FFFF);
    do_read("max_hi", TDR1_ADDR, 32'hFFFF_FFFF);
    timer_en = 1'b1;
    step();
    timer_en = 1'b0;
    do_read("wrap_lo", TDR0_ADDR, 32'h0);
    do_read("wrap_hi", TDR1_ADDR, 32'h0);

    // Prescaler /4 over 16 cycles
    div_en = 1'b1; div_val = 4'd3; timer_en = 1'b1;
    step(16);
    timer_en = 1'b0;
    do_read("presc_cnt", TDR0_ADDR, 32'd4);

    // Writes ignored while running
    div_en = 1'b0; timer_en = 1'b1;
    do_write(TDR1_ADDR, 32'h55);
    timer_en = 1'b0;
    do_read("wr_ign_hi", TDR1_ADDR, 32'h0);
    do_read("wr_ign_lo", TDR0_ADDR, 32'd5);

    // Compare at 10: int rises two edges after cnt==10
    load_cnt(64'd0);
    tcmp1 = 32'h0; tcmp0 = 32'd10; int_en = 1'b1; timer_en = 1'b1;
    step(11);
    chk_int("cmp_int_early", 1'b0);
    chk_int("cmp_int_rise", 1'b1);
    do_write(TISR_ADDR, 32'h0);
    chk_int("w0_no_clear", 1'b1);
    do_write(TISR_ADDR, 32'h1);
    chk_int("w1c_clear", 1'b0);
    step(5);
    chk_int("past_cmp", 1'b0);
    do_read("tisr_clr", TISR_ADDR, 32'h0);

    // Set and clear in the same cycle: set wins
    timer_en = 1'b0;
    load_cnt(64'd20);
    tcmp0 = 32'd20;
    timer_en = 1'b1;
    step();
    timer_en = 1'b0;
    do_write(TISR_ADDR, 32'h1);
    chk_int("set_wins", 1'b1);
    do_read("set_wins_rd", TISR_ADDR, 32'h1);
    do_write(TISR_ADDR, 32'h1);
    chk_int("clr_after", 1'b0);

    // int_en=0 suppresses the status
    int_en = 1'b0;
    load_cnt(64'd30);
    tcmp0 = 32'd30;
    timer_en = 1'b1;
    step();
    timer_en = 1'b0;
    step(2);
    chk_int("int_dis", 1'b0);

    // Debug halt
    tcmp1 = 32'h1;
    load_cnt(64'd100);
    timer_en = 1'b1;
    step(3);
    halt_req = 1'b1;
    step(5);
`ifdef TIMER_HALT_EN
    do_read("halt_hold", TDR0_ADDR, 32'd103);
    halt_req = 1'b0;
    step(2);
    timer_en = 1'b0;
    do_read("halt_resume", TDR0_ADDR, 32'd105);
`else
    do_read("halt_ign", TDR0_ADDR, 32'd108);
    halt_req = 1'b0;
    step(2);
    timer_en = 1'b0;
    do_read("halt_ign2", TDR0_ADDR, 32'd111);
`endif

    // Reset mid-count
    timer_en = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    do_read("midrst_lo", TDR0_ADDR, 32'h0);
    rst_n = 1'b1;
    timer_en = 1'b0;
    do_read("midrst_hi", TDR1_ADDR, 32'h0);

    step(2);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_cnt_cmp.md
Name: timer_cnt_cmp

Overview:
- Timer counter and compare-match stage that sits directly downstream of the TCMP0/TCMP1 compare registers.
- Holds a 64-bit up-counter (TDR1:TDR0) with a clock prescaler.
- Compares the counter against {tcmp1, tcmp0} and raises a sticky interrupt status (TISR), cleared by software writing 1.
- Decodes its own bus addresses for TDR0, TDR1 and TISR, and returns read data for them.

Parameters:
- TDR0_ADDR, 13'h04, bus address of counter low word.
- TDR1_ADDR, 13'h08, bus address of counter high word.
- TISR_ADDR, 13'h18, bus address of interrupt status (bit0, write-1-to-clear).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  13  register bus address.
- wr_data  in  32  register bus write data.
- wr_en  in  1  register bus write strobe.
- timer_en  in  1  counter run enable (from control register).
- div_en  in  1  prescaler enable.
- div_val  in  4  prescaler divide value.
- int_en  in  1  compare interrupt enable.
- halt_req  in  1  debug halt request (used only with the optional feature).
- tcmp0  in  32  compare value low word.
- tcmp1  in  32  compare value high word.
- rd_data  out  32  read data for TDR0/TDR1/TISR; 0 for any other address.
- tim_int  out  1  interrupt output; equals int_st.

Behaviour:
- Reset (async, rst_n low):
  - cnt = 64'h0, div_cnt = 4'h0, match_q = 0, int_st = 0.
  - tim_int = 0; rd_data follows the decode of the reset state.
- Prescaler:
  - div_en=0: tick every cycle.
  - div_en=1: div_cnt increments each cycle while timer_en=1. When div_cnt==div_val, tick=1 and div_cnt returns to 0, so the counter advances every (div_val+1) cycles.
  - timer_en=0: div_cnt forced to 0, tick=0.
- Counter:
  - timer_en=1 and tick: cnt <= cnt+1.
  - Wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
  - timer_en=0: cnt holds its value.
- Software load:
  - A write to TDR0_ADDR/TDR1_ADDR loads cnt[31:0]/cnt[63:32], but only when timer_en=0.
  - Writes while timer_en=1 are ignored.
- Compare:
  - match_q <= timer_en & (cnt == {tcmp1, tcmp0}), registered.
  - int_st sets the cycle after match_q=1 and int_en=1, i.e. 2 cycles after cnt reaches the compare value.
  - While cnt holds at the compare value, int_st re-sets every cycle.
- Clear:
  - A write to TISR_ADDR with wr_data[0]=1 clears int_st.
  - A set in the same cycle wins over the clear.
  - wr_data[0]=0 has no effect.
- Read mux (combinational, zero latency):
  - TDR0 -> cnt[31:0]; TDR1 -> cnt[63:32].
  - TISR -> {31'b0, int_st}.
  - Any other address -> 32'h0.
- int_en=0: match is still computed, but int_st is not set; an existing int_st is retained until cleared.
- Reset asserted mid-count: all state returns to reset values immediately.

Optional Feature:
- Macro: TIMER_HALT_EN.
- Defined: halt_req=1 freezes cnt, div_cnt and match_q, exactly as if tick=0 and the compare were disabled. int_st can still be cleared. Counting resumes on the cycle after halt_req falls.
- Undefined: halt_req is ignored; the port remains for interface stability.

Decomposition:
- Shared package: TDR0/TDR1/TISR/TCMP address constants, the 13-bit address width, and the 64-bit counter width constant.
- One sub-module is natural: timer_prescaler (div_cnt and tick generation). Counter, compare, status and read mux stay in the top.

Test Plan:
- Reset, then read TDR0/TDR1/TISR -> 0, 0, 0; tim_int=0.
- timer_en=0, write TDR0=32'hFFFF_FFFE and TDR1=32'hFFFF_FFFF, then timer_en=1, div_en=0 -> reads ...FFFF, then 0 after the wrap.
- div_en=1, div_val=4'd3, timer_en=1 for 16 cycles -> cnt=4.
- tcmp1=0, tcmp0=10, int_en=1, count from 0 -> tim_int rises 2 cycles after cnt==10. Write TISR=1 -> tim_int=0 next cycle, and stays 0 after cnt passes 10.
- Set event and TISR W1C in the same cycle -> int_st stays 1.
- With TIMER_HALT_EN defined: halt_req=1 for 5 cycles mid-count -> cnt unchanged during the halt and resumes +1 per tick afterwards.
